mem_ctrl: RTL

- Memory controller between the CPU core and the single-port word RAM.
- Arbitrates between the instruction-fetch port and the load/store port, and converts byte addresses to word indices.
- Performs sub-word stores by read-modify-write, and extracts and extends sub-word loads.
- Drives the RAM's address, load strobe and write data; consumes the RAM's read data.

---
 rtl/mem_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrating word-RAM controller with sub-word load extraction and read-modify-write stores
// Optional feature macro: MEM_CTRL_MISALIGN_TRAP_EN traps misaligned data accesses (mem_err) instead of aligning down.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr -> if_valid/if_data
//                                   instruction fetch port (full word)
//   mem_req/mem_we/mem_size/mem_unsigned/mem_addr/mem_wdata -> mem_valid/mem_rdata/mem_err
//                                   load/store port
//   busy                            high whenever not IDLE
//   ram_adr/ram_load/ram_in <- ram_out
//                                   single-port word RAM (word index, write strobe, write data, comb read data)
module mem_ctrl #(
    parameter int MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        busy,
    output logic [31:0] ram_adr,
    output logic        ram_load,
    output logic [31:0] ram_in,
    input  logic [31:0] ram_out
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD    = 3'd1;
    localparam logic [2:0] WR_RD = 3'd2;
    localparam logic [2:0] WR    = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;
    localparam logic [31:0] IDX_MASK = 32'(MEM_SIZE - 1);

    logic [2:0]  state;
    logic [31:0] addr, wdata, old;
    logic [1:0]  size;
    logic        uns, data_port, err, mis;
    logic [7:0]  sh_b;
    logic [15:0] sh_h;
    logic [31:0] ext, lane_m, lane_d, merged;

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    assign mis = mem_size == 2'd1 ? mem_addr[0] : (mem_size[1] & |mem_addr[1:0]);
`else
    assign mis = 1'b0;
`endif

    // size[1] covers both word encodings (2 and 3); low address bits below the size are ignored
    assign sh_b   = ram_out[{addr[1:0], 3'b000} +: 8];
    assign sh_h   = ram_out[{addr[1], 4'b0000} +: 16];
    assign ext    = size[1] ? ram_out :
                    size[0] ? {{16{~uns & sh_h[15]}}, sh_h} : {{24{~uns & sh_b[7]}}, sh_b};
    assign lane_m = size[0] ? 32'h0000_FFFF << {addr[1], 4'b0000} : 32'h0000_00FF << {addr[1:0], 3'b000};
    assign lane_d = size[0] ? {16'b0, wdata[15:0]} << {addr[1], 4'b0000} : {24'b0, wdata[7:0]} << {addr[1:0], 3'b000};
    assign merged = size[1] ? wdata : (old & ~lane_m) | lane_d;

    assign ram_adr   = (state == RD || state == WR_RD || state == WR) ? ({2'b00, addr[31:2]} & IDX_MASK) : '0;
    assign ram_load  = state == WR;
    assign ram_in    = ram_load ? merged : '0;
    assign if_valid  = state == RESP && !data_port;
    assign mem_valid = state == RESP && data_port;
    assign mem_err   = mem_valid & err;
    assign busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            wdata     <= '0;
            old       <= '0;
            size      <= '0;
            uns       <= 1'b0;
            data_port <= 1'b0;
            err       <= 1'b0;
            if_data   <= '0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        data_port <= 1'b1;
                        addr      <= mem_addr;
                        size      <= mem_size;
                        uns       <= mem_unsigned;
                        wdata     <= mem_wdata;
                        err       <= mis;
                        if (mis) mem_rdata <= '0;
                        state     <= mis ? RESP : !mem_we ? RD : mem_size[1] ? WR : WR_RD;
                    end else if (if_req) begin
                        data_port <= 1'b0;
                        addr      <= if_addr;
                        size      <= 2'd2;
                        uns       <= 1'b1;
                        err       <= 1'b0;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (data_port) mem_rdata <= ext;
                    else if_data <= ram_out;
                    state <= RESP;
                end
                WR_RD: begin
                    old   <= ram_out;
                    state <= WR;
                end
                WR: begin
                    mem_rdata <= '0;
                    state     <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
